// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side controller of a dual-clock FIFO: write address,
//               Gray write pointer, read-pointer synchroniser and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int AF_TH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk_i,
  input  logic              wr_rst_i,
  input  logic              wr_en_i,
  input  logic              ovf_clr_i,
  input  logic [ADDR_W:0]   rd_ptr_gray_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              mem_we_o,
  output logic [ADDR_W:0]   wr_ptr_gray_o,
  output logic              fifo_full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   wr_level_o,
  output logic              overflow_o
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;

  assign rq = sync_q[SYNC_STAGES-1];

  // Reset gates the strobe so nothing reaches the RAM while state is cleared.
  assign mem_we_o = wr_en_i & ~full_q & ~wr_rst_i;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, mem_we_o};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    level_d = wbin_d - rbin;
    // Full when write pointer is one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rq[PW-1:PW-2], rq[PW-3:0]});
    af_d    = (level_d >= PW'(AF_TH));
    ovf_d   = (wr_en_i & full_q) | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_addr_o     = wbin_q[ADDR_W-1:0];
  assign wr_ptr_gray_o = wgray_q;
  assign fifo_full_o   = full_q;
  assign almost_full_o = af_q;
  assign wr_level_o    = level_q;
  assign overflow_o    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Directed scoreboard bench for fifo_wr_ctrl (AF_TH=6 and AF_TH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       ovf_clr;
  logic [3:0] rd_gray;

  logic [2:0] wr_addr, wr_addr8;
  logic       mem_we, mem_we8;
  logic [3:0] wgray, wgray8;
  logic       full, full8;
  logic       af, af8;
  logic [3:0] lvl, lvl8;
  logic       ovf, ovf8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  fifo_wr_ctrl #(.ADDR_W(3), .AF_TH(6), .SYNC_STAGES(2)) u_dut (
    .wr_clk_i      (clk),
    .wr_rst_i      (rst),
    .wr_en_i       (wr_en),
    .ovf_clr_i     (ovf_clr),
    .rd_ptr_gray_i (rd_gray),
    .wr_addr_o     (wr_addr),
    .mem_we_o      (mem_we),
    .wr_ptr_gray_o (wgray),
    .fifo_full_o   (full),
    .almost_full_o (af),
    .wr_level_o    (lvl),
    .overflow_o    (ovf)
  );

  fifo_wr_ctrl #(.ADDR_W(3), .AF_TH(8), .SYNC_STAGES(2)) u_dut8 (
    .wr_clk_i      (clk),
    .wr_rst_i      (rst),
    .wr_en_i       (wr_en),
    .ovf_clr_i     (ovf_clr),
    .rd_ptr_gray_i (rd_gray),
    .wr_addr_o     (wr_addr8),
    .mem_we_o      (mem_we8),
    .wr_ptr_gray_o (wgray8),
    .fifo_full_o   (full8),
    .almost_full_o (af8),
    .wr_level_o    (lvl8),
    .overflow_o    (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int addr, input int g, input bit f,
                      input bit a, input int l, input bit o);
    exp_t e;
    e.tag  = tag;
    e.addr = addr[2:0];
    e.gray = g[3:0];
    e.full = f;
    e.af   = a;
    e.lvl  = l[3:0];
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".addr"},  32'(wr_addr), 32'(e.addr));
    check({e.tag, ".gray"},  32'(wgray),   32'(e.gray));
    check({e.tag, ".full"},  32'(full),    32'(e.full));
    check({e.tag, ".af"},    32'(af),      32'(e.af));
    check({e.tag, ".level"}, 32'(lvl),     32'(e.lvl));
    check({e.tag, ".ovf"},   32'(ovf),     32'(e.ovf));
    check({e.tag, ".full8"}, 32'(full8),   32'(e.full));
    check({e.tag, ".af8"},   32'(af8),     32'(e.full));
  endtask

  task automatic pop_check();
    @(posedge clk);
    #1;
    compare_now();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rd_gray = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0);
    compare_now();
    wr_en = 1'b1;
    #1;
    check("we_in_reset", 32'(mem_we), 32'd0);
    rst = 1'b0;

    for (int k = 1; k <= 3; k++) begin
      push("burst", k, gray(k), 0, 0, k, 0);
      pop_check();
    end

    // Async reset between edges with the write request still high.
    #3 rst = 1'b1;
    #1;
    push("async_rst", 0, 0, 0, 0, 0, 0);
    compare_now();
    check("we_async_rst", 32'(mem_we), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("first_we", 32'(mem_we), 32'd1);
    check("first_addr", 32'(wr_addr), 32'd0);

    for (int k = 1; k <= 8; k++) begin
      push("fill", k % 8, gray(k), k == 8, k >= 6, k, 0);
      pop_check();
    end

    check("we_blocked", 32'(mem_we), 32'd0);
    push("ovf_set", 0, 4'b1100, 1, 1, 8, 1);
    pop_check();
    ovf_clr = 1'b1;
    push("ovf_set_wins", 0, 4'b1100, 1, 1, 8, 1);
    pop_check();
    wr_en = 1'b0;
    push("ovf_clear", 0, 4'b1100, 1, 1, 8, 0);
    pop_check();
    ovf_clr = 1'b0;

    rd_gray = 4'b0010;
    push("release_e1", 0, 4'b1100, 1, 1, 8, 0);
    pop_check();
    push("release_e2", 0, 4'b1100, 1, 1, 8, 0);
    pop_check();
    push("release_e3", 0, 4'b1100, 0, 0, 5, 0);
    pop_check();

    wr_en = 1'b1;
    push("pre_wrap", 1, gray(9), 0, 1, 6, 0);
    pop_check();
    wr_en = 1'b0;
    rd_gray = 4'b1101;
    push("rd9_e1", 1, gray(9), 0, 1, 6, 0);
    pop_check();
    push("rd9_e2", 1, gray(9), 0, 1, 6, 0);
    pop_check();
    push("rd9_e3", 1, gray(9), 0, 0, 0, 0);
    pop_check();

    wr_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push("wrap", (9 + k) % 8, gray((9 + k) % 16), k == 8, k >= 6, k, 0);
      pop_check();
    end
    wr_en = 1'b0;
    check("wrap_gray_final", 32'(wgray), 32'b0001);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
